alu_cmd_driver: RTL and testbench

Command-side front end for the 8-bit combinational ALU. Accepts queued operation requests over a valid/ready stream, drives the ALU's `a`/`b`/`op` inputs from registered operands, and samples `result`/`zero`/`overflow`. Returns each outcome as a response beat with backpressure. It sits between an instruction or test sequencer and the ALU, and owns all sequencing, buffering and overflow accounting.

---
 rtl/alu_drv_pkg.sv | 35 +++
 rtl/alu_drv_fifo.sv | 51 +++++
 rtl/alu_cmd_driver.sv | 178 +++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_drv_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : alu_drv_pkg                                                   |
// | Desc     : Opcodes, FSM state encoding and FIFO entry width for the      |
// |            ALU command driver. Entry width depends on ALU_DRV_CHAIN_EN.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_drv_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Entry layout, MSB first: [chain,] op[2:0], a[7:0], b[7:0]
`ifdef ALU_DRV_CHAIN_EN
    localparam int C_ENTRY_W = 20;
`else
    localparam int C_ENTRY_W = 19;
`endif

endpackage

`default_nettype wire

// File: rtl/alu_drv_fifo.sv
// +--------------------------------------------------------------------------+
// | Module   : alu_drv_fifo                                                  |
// | Desc     : Synchronous FIFO with full/empty flags and first-word         |
// |            fall-through read port.                                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_drv_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/alu_cmd_driver.sv
// +--------------------------------------------------------------------------+
// | Module   : alu_cmd_driver                                                |
// | Desc     : Queues ALU commands, drives registered operands, returns      |
// |            results as backpressured responses. Macro: ALU_DRV_CHAIN_EN.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_chain,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [2:0]       rsp_op,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_rsp_hs;
    logic                   w_full;
    logic                   w_empty;
    logic [C_ENTRY_W-1:0]   w_push_data;
    logic [C_ENTRY_W-1:0]   w_head;
    logic [7:0]             r_alu_a;
    logic [7:0]             r_alu_b;
    logic [2:0]             r_alu_op;
    logic                   r_rsp_valid;
    logic [7:0]             r_rsp_result;
    logic                   r_rsp_zero;
    logic                   r_rsp_overflow;
    logic [2:0]             r_rsp_op;
    logic [CNT_W-1:0]       r_ovf_count;

`ifdef ALU_DRV_CHAIN_EN
    logic [7:0] r_last;
    assign w_push_data = {cmd_chain, cmd_op, cmd_a, cmd_b};
`else
    logic w_unused_chain;
    assign w_unused_chain = cmd_chain;
    assign w_push_data    = {cmd_op, cmd_a, cmd_b};
`endif

    assign w_push = cmd_valid && !w_full;

    alu_drv_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (C_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_data),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_nxt = ST_DRIVE;
            ST_DRIVE: w_state_nxt = ST_HOLD;
            ST_HOLD:  if (rsp_ready) w_state_nxt = w_empty ? ST_IDLE : ST_DRIVE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // rsp_valid is always set in HOLD, so rsp_ready alone marks the handshake.
    always_comb begin
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_rsp_hs  = 1'b0;
        case (r_state)
            ST_IDLE:  w_pop = !w_empty;
            ST_DRIVE: w_capture = 1'b1;
            ST_HOLD: begin
                w_rsp_hs = rsp_ready;
                w_pop    = rsp_ready && !w_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_pop) begin
            r_alu_op <= w_head[18:16];
            r_alu_b  <= w_head[7:0];
`ifdef ALU_DRV_CHAIN_EN
            r_alu_a  <= w_head[19] ? r_last : w_head[15:8];
`else
            r_alu_a  <= w_head[15:8];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_op       <= '0;
        end else if (w_capture) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= alu_result;
            r_rsp_zero     <= alu_zero;
            r_rsp_overflow <= alu_overflow;
            r_rsp_op       <= r_alu_op;
        end else if (w_rsp_hs) begin
            r_rsp_valid    <= 1'b0;
        end
    end

`ifdef ALU_DRV_CHAIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_last <= '0;
        else if (w_capture) r_last <= alu_result;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (w_rsp_hs && r_rsp_overflow && (r_ovf_count != {CNT_W{1'b1}})) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

    assign cmd_ready    = !w_full;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_op       = r_rsp_op;
    assign ovf_count    = r_ovf_count;
    assign busy         = !w_empty || (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_cmd_driver                                             |
// | Desc     : Directed self-checking bench for alu_cmd_driver with a small  |
// |            behavioural 8-bit ALU. Macro: ALU_DRV_CHAIN_EN.               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_cmd_driver;
    import alu_drv_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_overflow;
    logic [2:0] rsp_op;
    logic [7:0] ovf_count;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    alu_cmd_driver #(.DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_chain    (cmd_chain),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_op       (rsp_op),
        .ovf_count    (ovf_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: signed overflow on ADD/SUB only.
    logic [7:0] m_res;
    logic       m_ovf;
    always_comb begin
        m_res = 8'h00;
        m_ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                m_res = alu_a + alu_b;
                m_ovf = (alu_a[7] == alu_b[7]) && (m_res[7] != alu_a[7]);
            end
            OP_SUB: begin
                m_res = alu_a - alu_b;
                m_ovf = (alu_a[7] != alu_b[7]) && (m_res[7] != alu_a[7]);
            end
            OP_AND: m_res = alu_a & alu_b;
            OP_OR:  m_res = alu_a | alu_b;
            OP_XOR: m_res = alu_a ^ alu_b;
            OP_SHL: m_res = alu_a << alu_b[2:0];
            OP_SHR: m_res = alu_a >> alu_b[2:0];
            default: m_res = {7'b0, ($signed(alu_a) < $signed(alu_b))};
        endcase
    end
    assign alu_result   = m_res;
    assign alu_zero     = (m_res == 8'h00);
    assign alu_overflow = m_ovf;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic ch);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = ch;
        step();
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b ready=%b busy=%b want 0/1/0", rsp_valid, cmd_ready, busy);
        end
        checks++;
        if (ovf_count !== 8'h00 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'b000 || rsp_result !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs: ovf=%h a=%h b=%h op=%h res=%h want all 0", ovf_count, alu_a, alu_b, alu_op, rsp_result);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_latency();
        rsp_ready = 1'b1;
        send_cmd(OP_ADD, 8'h10, 8'h20, 1'b0);    // accepted at E0
        step();                                  // E0+1: pop into operand regs
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 8'h10 || alu_b !== 8'h20 || alu_op !== OP_ADD || busy !== 1'b1) begin
            failures++;
            $display("FAIL add_drive: valid=%b a=%h b=%h op=%h busy=%b want 0/10/20/0/1", rsp_valid, alu_a, alu_b, alu_op, busy);
        end
        step();                                  // E0+2: response captured
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h30 || rsp_zero !== 1'b0 || rsp_overflow !== 1'b0 || rsp_op !== OP_ADD) begin
            failures++;
            $display("FAIL add_rsp: valid=%b res=%h z=%b o=%b op=%h want 1/30/0/0/0", rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_op);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_done: valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_overflow();
        send_cmd(OP_ADD, 8'h7F, 8'h01, 1'b0);
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h80 || rsp_overflow !== 1'b1 || ovf_count !== 8'h00) begin
            failures++;
            $display("FAIL ovf_rsp: valid=%b res=%h o=%b cnt=%h want 1/80/1/00", rsp_valid, rsp_result, rsp_overflow, ovf_count);
        end
        step();
        checks++;
        if (ovf_count !== 8'h01) begin
            failures++;
            $display("FAIL ovf_count: got %h want 01", ovf_count);
        end
    endtask

    task automatic test_sub_zero();
        send_cmd(OP_SUB, 8'h05, 8'h05, 1'b0);
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h00 || rsp_zero !== 1'b1 || rsp_overflow !== 1'b0 || rsp_op !== OP_SUB) begin
            failures++;
            $display("FAIL sub_zero: valid=%b res=%h z=%b o=%b op=%h want 1/00/1/0/1", rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_op);
        end
        step();
        checks++;
        if (ovf_count !== 8'h01) begin
            failures++;
            $display("FAIL sub_ovf_count: got %h want 01", ovf_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] v_op  [5] = '{OP_ADD, OP_SUB, OP_XOR, OP_OR,  OP_AND};
        logic [7:0] v_a   [5] = '{8'h01,  8'h09,  8'hF0,  8'h0A,  8'hF0};
        logic [7:0] v_b   [5] = '{8'h01,  8'h03,  8'hFF,  8'h50,  8'h3C};
        logic [7:0] v_exp [5] = '{8'h02,  8'h06,  8'h0F,  8'h5A,  8'h30};
        int n = 0;
        logic rdy;
        rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = 1'b1;
            cmd_op    = v_op[n % 5];
            cmd_a     = v_a[n % 5];
            cmd_b     = v_b[n % 5];
            cmd_chain = 1'b0;
            rdy       = cmd_ready;
            step();
            if (rdy) n++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (n !== 5 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL capacity: accepted=%0d ready=%b busy=%b want 5/0/1", n, cmd_ready, busy);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h02) begin
            failures++;
            $display("FAIL stall_hold: valid=%b res=%h want 1/02", rsp_valid, rsp_result);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== v_exp[i] || rsp_op !== v_op[i]) begin
                failures++;
                $display("FAIL drain_%0d: valid=%b res=%h op=%h want 1/%h/%h", i, rsp_valid, rsp_result, rsp_op, v_exp[i], v_op[i]);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL drain_gap_%0d: valid=%b want 0", i, rsp_valid);
            end
            if (i < 4) step();
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || ovf_count !== 8'h01) begin
            failures++;
            $display("FAIL drain_end: busy=%b ready=%b cnt=%h want 0/1/01", busy, cmd_ready, ovf_count);
        end
    endtask

    task automatic test_chain();
        logic [7:0] exp [2];
        int cyc;
        exp[0] = 8'h07;
`ifdef ALU_DRV_CHAIN_EN
        exp[1] = 8'h11;
`else
        exp[1] = 8'h2A;
`endif
        rsp_ready = 1'b1;
        send_cmd(OP_ADD, 8'h03, 8'h04, 1'b0);
        send_cmd(OP_ADD, 8'h20, 8'h0A, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cyc = 0;
            while (!rsp_valid && cyc < 10) begin
                step();
                cyc++;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp[k]) begin
                failures++;
                $display("FAIL chain_%0d: valid=%b res=%h want 1/%h", k, rsp_valid, rsp_result, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_in_hold();
        int cyc = 0;
        rsp_ready = 1'b0;
        send_cmd(OP_ADD, 8'h7F, 8'h01, 1'b0);
        send_cmd(OP_OR, 8'h01, 8'h02, 1'b0);
        while (!rsp_valid && cyc < 10) begin
            step();
            cyc++;
        end
        rsp_ready = 1'b1;
        step();                                  // overflow response consumed
        rsp_ready = 1'b0;
        step();
        step();                                  // second response held
        checks++;
        if (rsp_valid !== 1'b1 || ovf_count !== 8'h02 || rsp_result !== 8'h03) begin
            failures++;
            $display("FAIL hold_pre: valid=%b cnt=%h res=%h want 1/02/03", rsp_valid, ovf_count, rsp_result);
        end
        send_cmd(OP_ADD, 8'h01, 8'h01, 1'b0);    // queued behind the held response
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || ovf_count !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: valid=%b ready=%b busy=%b cnt=%h want 0/1/0/00", rsp_valid, cmd_ready, busy, ovf_count);
        end
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_chain = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_add_latency();
        test_overflow();
        test_sub_zero();
        test_back_to_back();
        test_chain();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
